fp_add_scheduler: RTL and testbench

//  Round-robin scheduler sharing one adder_32 FP32 adder among NUM_REQ requesters.

---
 rtl/fp_add_scheduler.sv | 177 +++++++++++++++++
 tb/tb_fp_add_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_scheduler.sv
// ---------------------------------------------------------------------------
// fp_add_scheduler
//   Round-robin scheduler that shares one pipelined FP32 adder among NUM_REQ
//   requesters. At most one operand pair is launched per cycle. Each launch
//   carries its requester ID through a tag pipeline that matches the adder
//   latency. The tagged sum is then written into an output FIFO. Launches are
//   credit-limited, so every result in flight always has a free FIFO slot.
//
// Ports
//   clk_n       in   clock, all state updates on the rising edge
//   rst_n       in   synchronous active-low reset
//   req_valid   in   [NUM_REQ]        requester i presents an operand pair
//   req_ready   out  [NUM_REQ]        one-hot grant (or zero) this cycle
//   req_a       in   [NUM_REQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b       in   [NUM_REQ*WIDTH]  operand B, same packing
//   add_a       out  [WIDTH]          registered operand A to the shared adder
//   add_b       out  [WIDTH]          registered operand B to the shared adder
//   add_result  in   [WIDTH]          adder sum, ADD_LAT edges after launch
//   rsp_valid   out                   FIFO head valid
//   rsp_ready   in                    consumer pops the head
//   rsp_id      out  [ID_W]           requester index of the head (0 when empty)
//   rsp_data    out  [WIDTH]          sum at the head (0 when empty)
//   busy        out                   launch in flight or FIFO non-empty
// ---------------------------------------------------------------------------
module fp_add_scheduler #(
  parameter int WIDTH      = 32,
  parameter int NUM_REQ    = 4,
  parameter int ADD_LAT    = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk_n,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH-1:0]         add_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  // Arbitration
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_id;
  logic [NUM_REQ-1:0] grant_vec;
  logic               grant_found;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               can_issue;
  logic               issue;

  // Tag pipeline, one stage per adder latency cycle
  logic [ADD_LAT-1:0] stage_valid;
  logic [ID_W-1:0]    stage_id [ADD_LAT];
  logic [CNT_W-1:0]   in_flight;

  // Output FIFO
  logic [ID_W-1:0]    mem_id   [FIFO_DEPTH];
  logic [WIDTH-1:0]   mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic               push;
  logic               pop;
  logic [SUM_W-1:0]   credit_used;

  // Round-robin search: walk offsets from rr_ptr and take the first valid
  // requester. Both loops have constant bounds so every index is static.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    grant_vec   = '0;
    sel_a       = '0;
    sel_b       = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_found && req_valid[i] &&
            (((int'(rr_ptr) + off) % NUM_REQ) == i)) begin
          grant_found  = 1'b1;
          grant_id     = ID_W'(i);
          grant_vec[i] = 1'b1;
          sel_a        = req_a[i*WIDTH +: WIDTH];
          sel_b        = req_b[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < ADD_LAT; i++) begin
      in_flight = in_flight + CNT_W'(stage_valid[i]);
    end
  end

  // Credit comes only from registered counts, so a pop frees its slot for
  // issue one cycle later.
  assign credit_used = SUM_W'(in_flight) + SUM_W'(fifo_count);
  assign can_issue   = credit_used < SUM_W'(FIFO_DEPTH);

  // Grant is masked while reset is held so nothing looks accepted then.
  assign req_ready = (can_issue && rst_n) ? grant_vec : '0;
  assign issue     = grant_found && can_issue && rst_n;

  assign push      = stage_valid[ADD_LAT-1];
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid && rsp_ready;

  // Head fields read as zero while empty because FIFO storage is not reset.
  assign rsp_id    = rsp_valid ? mem_id[rd_ptr]   : '0;
  assign rsp_data  = rsp_valid ? mem_data[rd_ptr] : '0;
  assign busy      = (in_flight != '0) || rsp_valid;

  always_ff @(posedge clk_n) begin
    if (!rst_n) begin
      add_a       <= '0;
      add_b       <= '0;
      rr_ptr      <= '0;
      stage_valid <= '0;
      for (int i = 0; i < ADD_LAT; i++) begin
        stage_id[i] <= '0;
      end
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
    end else begin
      if (issue) begin
        add_a  <= sel_a;
        add_b  <= sel_b;
        rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end

      stage_valid[0] <= issue;
      stage_id[0]    <= grant_id;
      for (int i = 1; i < ADD_LAT; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_id[i]    <= stage_id[i-1];
      end

      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset; only the pointers and count define contents.
  always_ff @(posedge clk_n) begin
    if (push) begin
      mem_id[wr_ptr]   <= stage_id[ADD_LAT-1];
      mem_data[wr_ptr] <= add_result;
    end
  end

  // Credit accounting must make a push into a full FIFO impossible.
  no_full_push: assert property (@(posedge clk_n) disable iff (!rst_n)
    !(push && (fifo_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fp_add_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fp_add_scheduler
//   Directed bench for fp_add_scheduler. The shared adder is modelled as a
//   simple FP32 adder for positive normal operands, registered once so that
//   sums are captured ADD_LAT=2 edges after launch. Each requester presents a
//   fixed operand pair, so every response sum is a known constant.
// ---------------------------------------------------------------------------
module tb_fp_add_scheduler;
  localparam int WIDTH      = 32;
  localparam int NUM_REQ    = 4;
  localparam int ADD_LAT    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int ID_W       = 2;

  logic                     clk_n = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]         add_a;
  logic [WIDTH-1:0]         add_b;
  logic [WIDTH-1:0]         add_result;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_data;
  logic                     busy;

  int checks = 0;
  int errors = 0;

  always #5 clk_n = ~clk_n;

  fp_add_scheduler #(
    .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ADD_LAT(ADD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_n(clk_n), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  // Positive normal operands only, truncating.
  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] hi, lo;
    logic [7:0]  d;
    logic [23:0] mh, ml;
    logic [24:0] s;
    if (x[30:23] >= y[30:23]) begin hi = x; lo = y; end
    else begin hi = y; lo = x; end
    d  = hi[30:23] - lo[30:23];
    mh = {1'b1, hi[22:0]};
    ml = (d > 8'd23) ? 24'd0 : ({1'b1, lo[22:0]} >> d);
    s  = {1'b0, mh} + {1'b0, ml};
    if (s[24]) return {1'b0, hi[30:23] + 8'd1, s[23:1]};
    return {1'b0, hi[30:23], s[22:0]};
  endfunction

  // One register stage: launch at edge k, captured by the DUT at edge k+2.
  logic [WIDTH-1:0] add_pipe;
  always @(posedge clk_n) add_pipe <= fadd(add_a, add_b);
  assign add_result = add_pipe;

  // req0: 1.0+2.0=3.0, req1: 2+2=4, req2: 3+3=6, req3: 4+4=8
  function automatic logic [31:0] exp_sum(input logic [1:0] id);
    case (id)
      2'd0:    return 32'h4040_0000;
      2'd1:    return 32'h4080_0000;
      2'd2:    return 32'h40C0_0000;
      default: return 32'h4100_0000;
    endcase
  endfunction

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       rrdy;
    logic [3:0] rdy;
    logic       rv;
    logic [1:0] id;
    logic       bsy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic rst, input logic [3:0] valid, input logic rrdy,
                             input logic [3:0] rdy, input logic rv, input logic [1:0] id,
                             input logic bsy);
    vec_t t;
    t.rst = rst; t.valid = valid; t.rrdy = rrdy;
    t.rdy = rdy; t.rv = rv; t.id = id; t.bsy = bsy;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    req_a = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
    req_b = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h4000_0000};

    repeat (3) @(negedge clk_n);
    #1;
    check("reset req_ready", 32'(req_ready), 32'h0);
    check("reset rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset rsp_id",    32'(rsp_id),    32'h0);
    check("reset rsp_data",  rsp_data,       32'h0);
    check("reset busy",      32'(busy),      32'h0);
    check("reset add_a",     add_a,          32'h0);
    check("reset add_b",     add_b,          32'h0);

    // Single req0 launch, result two edges after accept.
    vecs.push_back(v(1'b0, 4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0));
    vecs.push_back(v(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0));
    // All valid, consumer always ready: rotating grants, responses in order.
    vecs.push_back(v(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0));
    vecs.push_back(v(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b1));
    vecs.push_back(v(1'b0, 4'b1111, 1'b1, 4'b0100, 1'b0, 2'd0, 1'b1));
    vecs.push_back(v(1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd0, 1'b1));
    vecs.push_back(v(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd1, 1'b1));
    vecs.push_back(v(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd2, 1'b1));
    vecs.push_back(v(1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd3, 1'b1));
    vecs.push_back(v(1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd0, 1'b1));
    vecs.push_back(v(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0));
    // Consumer stalled: four accepts fill the credit, then no grant.
    vecs.push_back(v(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b0));
    vecs.push_back(v(1'b0, 4'b1111, 1'b0, 4'b0010, 1'b0, 2'd0, 1'b1));
    vecs.push_back(v(1'b0, 4'b1111, 1'b0, 4'b0100, 1'b0, 2'd0, 1'b1));
    vecs.push_back(v(1'b0, 4'b1111, 1'b0, 4'b1000, 1'b1, 2'd0, 1'b1));
    vecs.push_back(v(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1));
    vecs.push_back(v(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1));
    vecs.push_back(v(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1));
    vecs.push_back(v(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1));
    // Pop from full: no grant in the pop cycle, grant the cycle after.
    vecs.push_back(v(1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1));
    vecs.push_back(v(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd1, 1'b1));
    vecs.push_back(v(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd2, 1'b1));
    vecs.push_back(v(1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd3, 1'b1));
    vecs.push_back(v(1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd0, 1'b1));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0));
    vecs.push_back(v(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0));
    // rr_ptr moved to 2 by a req1 grant; with req1 and req3 valid, 3 wins first.
    vecs.push_back(v(1'b0, 4'b0010, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b0));
    vecs.push_back(v(1'b0, 4'b1010, 1'b1, 4'b1000, 1'b0, 2'd0, 1'b1));
    vecs.push_back(v(1'b0, 4'b1010, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b1));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0));
    vecs.push_back(v(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0));
    // Reset with two launches in flight: nothing comes out, arbitration restarts at 0.
    vecs.push_back(v(1'b0, 4'b0011, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0));
    vecs.push_back(v(1'b0, 4'b0011, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b1));
    vecs.push_back(v(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0));
    vecs.push_back(v(1'b0, 4'b0011, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0));

    foreach (vecs[i]) begin
      @(negedge clk_n);
      rst_n     = !vecs[i].rst;
      req_valid = vecs[i].valid;
      rsp_ready = vecs[i].rrdy;
      #1;
      if (!vecs[i].rst) begin
        check($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(vecs[i].rdy));
        check($sformatf("row%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].rv));
        check($sformatf("row%0d rsp_id", i),    32'(rsp_id),    32'(vecs[i].id));
        check($sformatf("row%0d rsp_data", i),  rsp_data,
              vecs[i].rv ? exp_sum(vecs[i].id) : 32'h0);
        check($sformatf("row%0d busy", i),      32'(busy),      32'(vecs[i].bsy));
      end
    end

    // Hand sequence: rr_ptr is 1 here; lone req2 launch, operand path and latency.
    @(negedge clk_n);
    rst_n = 1'b1; req_valid = 4'b0100; rsp_ready = 1'b1;
    #1;
    check("hand grant req2", 32'(req_ready), 32'h4);
    @(negedge clk_n);
    req_valid = 4'b0000;
    #1;
    check("hand add_a launch", add_a, 32'h4040_0000);
    check("hand add_b launch", add_b, 32'h4040_0000);
    lat = 0;
    while (!rsp_valid && lat < 8) begin
      @(negedge clk_n);
      #1;
      lat++;
    end
    check("hand latency edges", 32'(lat), 32'd2);
    check("hand rsp_id",        32'(rsp_id), 32'd2);
    check("hand rsp_data",      rsp_data, 32'h40C0_0000);
    check("hand add_a hold",    add_a, 32'h4040_0000);
    @(negedge clk_n);
    #1;
    check("hand drained rsp_valid", 32'(rsp_valid), 32'h0);
    check("hand drained busy",      32'(busy),      32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
